alu_exec_stage: RTL and testbench
=================================

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 Parameter RSTATUS_REG, default 30: destination register written on an arithmetic-overflow exception.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream holds a valid decoded instruction.
REQ-005 in_ready  output  1  stage accepts the instruction this cycle.
REQ-006 in_kind  input  2  00 R-type ALU, 01 ADDI, 10 BNE, 11 BLT.
REQ-007 in_opcode  input  5  ALU opcode: 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 SLL, 00101 SRA.
REQ-008 in_shamt  input  5  shift amount for SLL/SRA.
REQ-009 in_a  input  32  operand A (rs value).
REQ-010 in_b  input  32  operand B (rt value or sign-extended immediate).
REQ-011 in_rd  input  5  destination register index.
REQ-012 out_valid  output  1  writeback/branch result valid.
REQ-013 out_ready  input  1  downstream accepts the result this cycle.
REQ-014 out_result  output  32  value to write back.
REQ-015 out_rd  output  5  register index to write.
REQ-016 out_we  output  1  register write enable.
REQ-017 out_taken  output  1  branch-taken flag; 0 for non-branch kinds.

Function
REQ-018 Two register stages SHALL exist: S1 (operands, opcode, shamt, rd, kind, s1_valid) and S2 (outputs, out_valid); the ALU SHALL be driven combinationally from S1.
REQ-019 Transfers SHALL occur on in_valid&&in_ready (input) and out_valid&&out_ready (output) at the rising edge.
REQ-020 s1_adv = s1_valid && (!out_valid || out_ready); in_ready = !s1_valid || s1_adv, computed combinationally.
REQ-021 An instruction accepted at edge k SHALL appear with out_valid=1 after edge k+1 when not stalled; throughput one per cycle with out_ready=1.
REQ-022 While out_valid && !out_ready, all out_* SHALL hold stable and S1 SHALL hold.
REQ-023 Simultaneous S1 advance and new acceptance SHALL reload S1 on the same edge without bubble; ordering SHALL be preserved.
REQ-024 ADDI SHALL force opcode 00000; BNE/BLT SHALL force opcode 00001, regardless of in_opcode.
REQ-025 R-type/ADDI: out_result = ALU result, out_rd = rd, out_we = (rd != 0), out_taken = 0.
REQ-026 Overflow exception: ADD overflow -> result 1, ADDI overflow -> 2, SUB overflow -> 3; out_rd = RSTATUS_REG, out_we = 1; overflow ignored for other opcodes.
REQ-027 BNE: out_taken = isNotEqual; BLT: out_taken = isLessThan; out_we = 0, out_result = 0, out_rd = 0.
REQ-028 R-type opcodes above 00101 SHALL give out_result = 0, out_we = 0.

Reset
REQ-029 reset=1 at an edge SHALL clear s1_valid, out_valid, out_we, out_taken, out_result and out_rd to 0, dropping all in-flight instructions.
REQ-030 The cycle after reset deasserts, in_ready SHALL be 1; reset SHALL override simultaneous handshakes.

Structure
REQ-031 ALU opcode, in_kind encodings and rstatus codes (1, 2, 3) SHALL live in a shared package/include used by decode and this stage.
REQ-032 The existing alu module SHALL be the single sub-module instance, unmodified.
REQ-033 No other sub-modules; pipeline registers are written inline.

Verification
REQ-034 ADD 0x5+0x3 rd=7, out_ready=1 -> two cycles later out_result=0x8, out_rd=7, out_we=1, out_taken=0.
REQ-035 ADD 0x40000000+0x40000000 -> result 1, rd 30, we 1; same as ADDI -> 2; SUB 0x80000000-0x0F000000 -> 3.
REQ-036 BLT a=0x80000001 b=0x7FFFFFFF -> out_taken=1, out_we=0; BNE a=b=0 -> out_taken=0.
REQ-037 Stream four ADDs with out_ready low 3 cycles -> in_ready low after 2 accepted, outputs held stable, all four in order, none lost or duplicated.
REQ-038 Reset with S1 and S2 full -> next cycle out_valid=0, in_ready=1; later R-type to rd=0 -> out_we=0.
REQ-039 SLL a=0x1 shamt=16 rd=2 -> out_result=0x00010000, out_we=1.

Source files
------------

// File: rtl/alu_exec_stage_pkg.sv
// Shared decode/execute definitions: instruction kinds, ALU opcodes and the
// status codes written to the status register on arithmetic overflow.
package alu_exec_stage_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] KIND_RTYPE = 2'b00;
    localparam logic [1:0] KIND_ADDI  = 2'b01;
    localparam logic [1:0] KIND_BNE   = 2'b10;
    localparam logic [1:0] KIND_BLT   = 2'b11;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;

    localparam logic [DATA_W-1:0] RSTATUS_ADD  = 32'd1;
    localparam logic [DATA_W-1:0] RSTATUS_ADDI = 32'd2;
    localparam logic [DATA_W-1:0] RSTATUS_SUB  = 32'd3;

    // Immediate adds and branch compares ignore the encoded opcode field.
    function automatic logic [4:0] effective_opcode(input logic [1:0] kind,
                                                    input logic [4:0] opcode);
        case (kind)
            KIND_ADDI:          return OP_ADD;
            KIND_BNE, KIND_BLT: return OP_SUB;
            default:            return opcode;
        endcase
    endfunction

endpackage

// File: rtl/alu_exec_stage_alu.sv
// Combinational 32-bit ALU: add/sub with signed overflow, logic ops, shifts,
// plus equality and signed less-than flags for branch resolution.
module alu
    import alu_exec_stage_pkg::*;
(
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    input  logic        [4:0]        op_i,
    input  logic        [4:0]        shamt_i,
    output logic signed [DATA_W-1:0] result_o,
    output logic                     overflow_o,
    output logic                     not_equal_o,
    output logic                     less_than_o
);

    logic signed [DATA_W-1:0] sum;
    logic signed [DATA_W-1:0] diff;

    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;

    assign not_equal_o = (a_i != b_i);
    assign less_than_o = (a_i < b_i);

    always_comb begin
        result_o   = '0;
        overflow_o = 1'b0;
        case (op_i)
            OP_ADD: begin
                result_o   = sum;
                overflow_o = (a_i[DATA_W-1] == b_i[DATA_W-1]) &&
                             (sum[DATA_W-1] != a_i[DATA_W-1]);
            end
            OP_SUB: begin
                result_o   = diff;
                overflow_o = (a_i[DATA_W-1] != b_i[DATA_W-1]) &&
                             (diff[DATA_W-1] != a_i[DATA_W-1]);
            end
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_SLL:  result_o = a_i <<< shamt_i;
            OP_SRA:  result_o = a_i >>> shamt_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Two-stage execute: S1 latches the decoded instruction, the ALU evaluates
// from S1, and S2 holds the writeback/branch result under valid/ready flow.
module alu_exec_stage
    import alu_exec_stage_pkg::*;
#(
    parameter int unsigned RSTATUS_REG = 30
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [4:0]        in_opcode,
    input  logic [4:0]        in_shamt,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [4:0]        in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [4:0]        out_rd,
    output logic              out_we,
    output logic              out_taken
);

    localparam logic [4:0] RSTATUS_IDX = 5'(RSTATUS_REG);

    logic                     s1_valid_q;
    logic signed [DATA_W-1:0] s1_a_q;
    logic signed [DATA_W-1:0] s1_b_q;
    logic        [4:0]        s1_op_q;
    logic        [4:0]        s1_shamt_q;
    logic        [4:0]        s1_rd_q;
    logic        [1:0]        s1_kind_q;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_result_q, out_result_d;
    logic [4:0]        out_rd_q,     out_rd_d;
    logic              out_we_q,     out_we_d;
    logic              out_taken_q,  out_taken_d;

    logic                     s1_adv;
    logic                     in_fire;
    logic signed [DATA_W-1:0] alu_result;
    logic                     alu_ovf;
    logic                     alu_ne;
    logic                     alu_lt;

    assign s1_adv   = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s1_adv;
    assign in_fire  = in_valid && in_ready;

    alu u_alu (
        .a_i         (s1_a_q),
        .b_i         (s1_b_q),
        .op_i        (s1_op_q),
        .shamt_i     (s1_shamt_q),
        .result_o    (alu_result),
        .overflow_o  (alu_ovf),
        .not_equal_o (alu_ne),
        .less_than_o (alu_lt)
    );

    // S1: operand capture; reloads on the same edge it drains into S2.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
        end else if (in_fire) begin
            s1_valid_q <= 1'b1;
        end else if (s1_adv) begin
            s1_valid_q <= 1'b0;
        end
        if (in_fire) begin
            s1_a_q     <= in_a;
            s1_b_q     <= in_b;
            s1_op_q    <= effective_opcode(in_kind, in_opcode);
            s1_shamt_q <= in_shamt;
            s1_rd_q    <= in_rd;
            s1_kind_q  <= in_kind;
        end
    end

    // Writeback formatting: branches, overflow traps, illegal opcodes, normal ALU.
    always_comb begin
        out_result_d = '0;
        out_rd_d     = '0;
        out_we_d     = 1'b0;
        out_taken_d  = 1'b0;
        case (s1_kind_q)
            KIND_BNE: out_taken_d = alu_ne;
            KIND_BLT: out_taken_d = alu_lt;
            default: begin
                if (alu_ovf && (s1_op_q == OP_ADD)) begin
                    out_result_d = (s1_kind_q == KIND_ADDI) ? RSTATUS_ADDI : RSTATUS_ADD;
                    out_rd_d     = RSTATUS_IDX;
                    out_we_d     = 1'b1;
                end else if (alu_ovf && (s1_op_q == OP_SUB)) begin
                    out_result_d = RSTATUS_SUB;
                    out_rd_d     = RSTATUS_IDX;
                    out_we_d     = 1'b1;
                end else if (s1_op_q > OP_SRA) begin
                    out_rd_d     = s1_rd_q;
                end else begin
                    out_result_d = alu_result;
                    out_rd_d     = s1_rd_q;
                    out_we_d     = (s1_rd_q != 5'd0);
                end
            end
        endcase
    end

    // S2: result register, held while the consumer stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_rd_q     <= '0;
            out_we_q     <= 1'b0;
            out_taken_q  <= 1'b0;
        end else if (s1_adv) begin
            out_valid_q  <= 1'b1;
            out_result_q <= out_result_d;
            out_rd_q     <= out_rd_d;
            out_we_q     <= out_we_d;
            out_taken_q  <= out_taken_d;
        end else if (out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_rd     = out_rd_q;
    assign out_we     = out_we_q;
    assign out_taken  = out_taken_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: directed vectors push hand-computed
// results; a negedge monitor pops and compares on each output handshake.
module tb_alu_exec_stage;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        we;
        logic        taken;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_kind;
    logic [4:0]  in_opcode;
    logic [4:0]  in_shamt;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_taken;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic        hold_pend = 1'b0;
    logic [31:0] hold_result;
    logic [4:0]  hold_rd;
    logic        hold_we;
    logic        hold_taken;

    alu_exec_stage #(.RSTATUS_REG(30)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_opcode  (in_opcode),
        .in_shamt   (in_shamt),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_we     (out_we),
        .out_taken  (out_taken)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] kind, input logic [4:0] op, input logic [4:0] sh,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] e_res, input logic [4:0] e_rd,
                        input logic e_we, input logic e_taken);
        int waited = 0;
        in_valid  = 1'b1;
        in_kind   = kind;
        in_opcode = op;
        in_shamt  = sh;
        in_a      = a;
        in_b      = b;
        in_rd     = rd;
        forever begin
            @(negedge clock);
            if (in_ready) break;
            waited++;
            if (waited > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: in_ready stuck at 0 for rd=%0d", rd);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clock);
        sb_q.push_back('{result: e_res, rd: e_rd, we: e_we, taken: e_taken});
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (sb_q.size() != 0) begin
            @(posedge clock);
            waited++;
            if (waited > 100) begin
                n_checks++;
                n_fail++;
                $display("FAIL drain_timeout: %0d results never appeared", sb_q.size());
                sb_q.delete();
            end
        end
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (reset) begin
            hold_pend = 1'b0;
        end else begin
            if (out_valid && !out_ready) begin
                if (hold_pend) begin
                    check("hold_result", out_result, hold_result);
                    check("hold_rd", 32'(out_rd), 32'(hold_rd));
                    check("hold_we", 32'(out_we), 32'(hold_we));
                    check("hold_taken", 32'(out_taken), 32'(hold_taken));
                end
                hold_pend   = 1'b1;
                hold_result = out_result;
                hold_rd     = out_rd;
                hold_we     = out_we;
                hold_taken  = out_taken;
            end else begin
                hold_pend = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got result 0x%08h rd %0d, expected nothing",
                             out_result, out_rd);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("result", out_result, e.result);
                    check("rd", 32'(out_rd), 32'(e.rd));
                    check("we", 32'(out_we), 32'(e.we));
                    check("taken", 32'(out_taken), 32'(e.taken));
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_kind   = 2'b00;
        in_opcode = 5'd0;
        in_shamt  = 5'd0;
        in_a      = '0;
        in_b      = '0;
        in_rd     = 5'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_we", 32'(out_we), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        @(posedge clock);
        #1;

        // kind, op, shamt, a, b, rd  ->  result, rd, we, taken
        send(2'b00, 5'd0, 5'd0, 32'h5, 32'h3, 5'd7, 32'h8, 5'd7, 1'b1, 1'b0);
        send(2'b00, 5'd0, 5'd0, 32'h40000000, 32'h40000000, 5'd5, 32'd1, 5'd30, 1'b1, 1'b0);
        send(2'b01, 5'd3, 5'd0, 32'h40000000, 32'h40000000, 5'd5, 32'd2, 5'd30, 1'b1, 1'b0);
        send(2'b00, 5'd1, 5'd0, 32'h80000000, 32'h0F000000, 5'd6, 32'd3, 5'd30, 1'b1, 1'b0);
        send(2'b11, 5'd2, 5'd0, 32'h80000001, 32'h7FFFFFFF, 5'd9, 32'd0, 5'd0, 1'b0, 1'b1);
        send(2'b11, 5'd0, 5'd0, 32'h5, 32'h3, 5'd9, 32'd0, 5'd0, 1'b0, 1'b0);
        send(2'b10, 5'd0, 5'd0, 32'h0, 32'h0, 5'd4, 32'd0, 5'd0, 1'b0, 1'b0);
        send(2'b10, 5'd0, 5'd0, 32'h1, 32'h2, 5'd4, 32'd0, 5'd0, 1'b0, 1'b1);
        send(2'b00, 5'd4, 5'd16, 32'h1, 32'h0, 5'd2, 32'h00010000, 5'd2, 1'b1, 1'b0);
        send(2'b00, 5'd5, 5'd4, 32'h80000000, 32'h0, 5'd3, 32'hF8000000, 5'd3, 1'b1, 1'b0);
        send(2'b00, 5'd2, 5'd0, 32'h0000F0F0, 32'h0000FF00, 5'd4, 32'h0000F000, 5'd4, 1'b1, 1'b0);
        send(2'b00, 5'd3, 5'd0, 32'h0000F0F0, 32'h000FF000, 5'd4, 32'h000FF0F0, 5'd4, 1'b1, 1'b0);
        send(2'b00, 5'd1, 5'd0, 32'd10, 32'd3, 5'd6, 32'd7, 5'd6, 1'b1, 1'b0);
        send(2'b00, 5'd0, 5'd0, 32'h80000000, 32'hFFFFFFFF, 5'd8, 32'd1, 5'd30, 1'b1, 1'b0);
        send(2'b01, 5'd0, 5'd0, 32'd100, 32'hFFFFFFFF, 5'd12, 32'd99, 5'd12, 1'b1, 1'b0);
        send(2'b00, 5'd6, 5'd0, 32'h12345678, 32'h1, 5'd8, 32'd0, 5'd8, 1'b0, 1'b0);
        send(2'b00, 5'd1, 5'd0, 32'h1, 32'h1, 5'd11, 32'd0, 5'd11, 1'b1, 1'b0);
        drain();

        // Back-pressure: four ADDs with the consumer stalled.
        out_ready = 1'b0;
        send(2'b00, 5'd0, 5'd0, 32'd1, 32'd1, 5'd1, 32'd2, 5'd1, 1'b1, 1'b0);
        send(2'b00, 5'd0, 5'd0, 32'd2, 32'd2, 5'd2, 32'd4, 5'd2, 1'b1, 1'b0);
        @(negedge clock);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        fork
            send(2'b00, 5'd0, 5'd0, 32'd3, 32'd3, 5'd3, 32'd6, 5'd3, 1'b1, 1'b0);
            begin
                repeat (3) @(posedge clock);
                #1 out_ready = 1'b1;
            end
        join
        send(2'b00, 5'd0, 5'd0, 32'd4, 32'd4, 5'd4, 32'd8, 5'd4, 1'b1, 1'b0);
        drain();

        // Reset with both stages full and a handshake offered on the reset edge.
        out_ready = 1'b0;
        send(2'b00, 5'd0, 5'd0, 32'd7, 32'd7, 5'd1, 32'd14, 5'd1, 1'b1, 1'b0);
        send(2'b00, 5'd0, 5'd0, 32'd8, 32'd8, 5'd2, 32'd16, 5'd2, 1'b1, 1'b0);
        in_valid  = 1'b1;
        in_kind   = 2'b00;
        in_opcode = 5'd0;
        in_a      = 32'd9;
        in_b      = 32'd9;
        in_rd     = 5'd3;
        reset     = 1'b1;
        sb_q.delete();
        @(posedge clock);
        #1;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_out_we", 32'(out_we), 32'd0);
        check("flush_out_rd", 32'(out_rd), 32'd0);
        check("flush_out_result", out_result, 32'd0);
        check("flush_out_taken", 32'(out_taken), 32'd0);
        @(negedge clock);
        check("flush_no_ghost", 32'(out_valid), 32'd0);
        @(posedge clock);
        #1;

        send(2'b00, 5'd0, 5'd0, 32'd1, 32'd2, 5'd0, 32'd3, 5'd0, 1'b0, 1'b0);
        send(2'b00, 5'd0, 5'd0, 32'h5, 32'h3, 5'd7, 32'h8, 5'd7, 1'b1, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
